div_seq_ctrl: RTL and testbench

- Sequencing wrapper around the combinational 32-bit unsigned restoring divider (remainder in result[63:32], quotient in result[31:0]).
- Upstream, it accepts a start handshake, optionally converts signed operands to magnitudes, and drives the divider inputs.
- It waits a fixed settle period for the deep combinational path, then applies sign fix-up downstream and writes the HI (remainder) and LO (quotient) registers consumed by the datapath.
- It handles divide-by-zero without using the divider.

---
 rtl/div_seq_ctrl_pkg.sv | 15 +
 rtl/div_seq_ctrl_sign_mag.sv | 13 +
 rtl/div_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the divider sequencing wrapper.
// Used by the operand/result sign stage and the control FSM.
package div_seq_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FIX    = 2'd2
  } state_t;

endpackage

// File: rtl/div_seq_ctrl_sign_mag.sv
// Conditional 32-bit two's-complement negate, combinational (0 cycles).
// No handshake; output follows the inputs directly.
module sign_mag_32
  import div_seq_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_val,
  input  logic              i_neg,
  output logic [DATA_W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 32'd1) : i_val;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequences an external combinational divider: latch magnitudes, wait SETTLE_CYCLES, sign fix-up, write HI/LO.
// Latency SETTLE_CYCLES+1 edges (1 for divide-by-zero); start is ignored while busy.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                op_signed,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic [DATA_W-1:0]   div_a,
  output logic [DATA_W-1:0]   div_b,
  input  logic [2*DATA_W-1:0] div_result,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out
);

  localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dbz;
  logic [DATA_W-1:0]   r_div_a;
  logic [DATA_W-1:0]   r_div_b;
  logic [2*DATA_W-1:0] r_raw;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;
  logic                r_dbz_out;

  logic                w_accept;
  logic                w_capture;
  logic                w_write;
  logic                w_busy;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W-1:0]   w_fix_q;
  logic [DATA_W-1:0]   w_fix_r;

  sign_mag_32 u_mag_a (.i_val(dividend), .i_neg(op_signed & dividend[31]), .o_val(w_mag_a));
  sign_mag_32 u_mag_b (.i_val(divisor),  .i_neg(op_signed & divisor[31]),  .o_val(w_mag_b));
  sign_mag_32 u_fix_q (.i_val(r_raw[DATA_W-1:0]),        .i_neg(r_neg_q), .o_val(w_fix_q));
  sign_mag_32 u_fix_r (.i_val(r_raw[2*DATA_W-1:DATA_W]), .i_neg(r_neg_r), .o_val(w_fix_r));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_write     = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? ST_FIX : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == LP_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_write     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // On divide-by-zero the dividend magnitude is parked in the raw remainder slot,
  // so the normal remainder fix-up restores the original signed dividend for HI.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_raw     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_accept) begin
        r_neg_q <= op_signed & (dividend[31] ^ divisor[31]);
        r_neg_r <= op_signed & dividend[31];
        r_div_a <= w_mag_a;
        r_div_b <= w_mag_b;
        r_cnt   <= '0;
        r_dbz   <= (divisor == '0);
        if (divisor == '0) begin
          r_raw <= {w_mag_a, DIV_ZERO_QUOTIENT};
        end
      end else if (r_state == ST_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_raw <= div_result;
      end
      if (w_write) begin
        r_hi      <= w_fix_r;
        r_lo      <= r_dbz ? DIV_ZERO_QUOTIENT : w_fix_q;
        r_dbz_out <= r_dbz;
      end
    end
  end

  assign div_a       = r_div_a;
  assign div_b       = r_div_b;
  assign busy        = w_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural combinational divider alongside.
module tb_div_seq_ctrl;

  localparam int SETTLE = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Stand-in for the restoring divider: remainder high, quotient low.
  always_comb begin
    if (div_b == 32'd0) div_result = {div_a, 32'hFFFF_FFFF};
    else                div_result = {div_a % div_b, div_a / div_b};
  end

  div_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock(clock), .clear(clear), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    logic [31:0] r;
    r = (s && v[31]) ? (32'd0 - v) : v;
    return r;
  endfunction

  // Called at a sample point (#1 after an edge). Issues start, returns edges to done and busy count.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    op_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    check("div_a", {32'd0, div_a}, {32'd0, mag(s, a)});
    check("div_b", {32'd0, div_b}, {32'd0, mag(s, b)});
    do begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end while (!done && lat < 50);
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: no done after %0d edges, required %0d", lat, SETTLE + 1);
    end
  endtask

  initial begin
    int lat;
    int bc;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, SETTLE + 1};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, SETTLE + 1};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, SETTLE + 1};
    vecs[3] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, SETTLE + 1};
    vecs[4] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    vecs[5] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, SETTLE + 1};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, SETTLE + 1};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, SETTLE + 1};
    vecs[8] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, SETTLE + 1};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1, 1};

    // Reset state
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    check("rst_hi",   {32'd0, hi_out}, 64'd0);
    check("rst_lo",   {32'd0, lo_out}, 64'd0);
    check("rst_diva", {32'd0, div_a}, 64'd0);
    clear = 1'b1;
    tick();
    tick();

    // Table: each op starts in the done cycle of the previous one.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_lo", i),  {32'd0, lo_out}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_hi", i),  {32'd0, hi_out}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
      if (i == 0) check("v0_busy_cycles", 64'(bc), 64'(SETTLE + 1));
    end

    // done is a single-cycle pulse; HI/LO/flag hold afterwards
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
    check("hold_lo", {32'd0, lo_out}, 64'hFFFF_FFFF);
    check("hold_dbz", {63'd0, div_by_zero}, 64'd1);

    // start while busy is ignored
    op_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 50) begin tick(); lat++; end
    check("busy_ign_lat", 64'(lat), 64'(SETTLE + 1));
    check("busy_ign_lo", {32'd0, lo_out}, 64'd14);
    check("busy_ign_hi", {32'd0, hi_out}, 64'd2);
    tick();
    check("busy_ign_nodone", {63'd0, done}, 64'd0);
    check("busy_ign_idle", {63'd0, busy}, 64'd0);

    // Reset mid-operation (SETTLE)
    op_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_hi", {32'd0, hi_out}, 64'd0);
    check("mid_rst_lo", {32'd0, lo_out}, 64'd0);
    tick();
    tick();
    @(negedge clock);
    clear = 1'b1;
    bc = 0;
    for (int k = 0; k < SETTLE + 3; k++) begin
      tick();
      if (done) bc++;
    end
    check("mid_rst_no_done", 64'(bc), 64'd0);
    run_op(1'b0, 32'd20, 32'd6, lat, bc);
    check("post_rst_lat", 64'(lat), 64'(SETTLE + 1));
    check("post_rst_lo", {32'd0, lo_out}, 64'd3);
    check("post_rst_hi", {32'd0, hi_out}, 64'd2);
    check("post_rst_dbz", {63'd0, div_by_zero}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
